// File: rtl/mc_defs.sv
// Shared definitions for the multicycle MIPS control unit: state encodings, opcodes,
// funct codes, ALU op/control codes and the packed Moore control word.
package mc_defs;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       irwrite;
        logic       lord;
        logic       memwrite;
        logic       regdst;
        logic       regwrite;
        logic       memtoreg;
    } ctl_t;

    // FETCH control word; also the value every non-enable output holds in reset.
    function automatic ctl_t fetch_ctl();
        ctl_t c;
        c         = '0;
        c.irwrite = 1'b1;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
        c.pcwrite = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop + funct to an alucontrol code and flags supported R-type functs.
module mc_aludec
    import mc_defs::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol,
    output logic       o_funct_ok
);

    logic [2:0] w_funct_ctl;

    always_comb begin
        w_funct_ctl = ALUC_ADD;
        o_funct_ok  = 1'b1;
        case (i_funct)
            FUNCT_ADD: w_funct_ctl = ALUC_ADD;
            FUNCT_SUB: w_funct_ctl = ALUC_SUB;
            FUNCT_AND: w_funct_ctl = ALUC_AND;
            FUNCT_OR:  w_funct_ctl = ALUC_OR;
            FUNCT_SLT: w_funct_ctl = ALUC_SLT;
            default:   o_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (i_aluop)
            ALUOP_SUB:   o_alucontrol = ALUC_SUB;
            ALUOP_FUNCT: o_alucontrol = w_funct_ctl;
            default:     o_alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction, driving datapath controls.
// Optional addi support is built when MC_ADDI_EN is defined.
module mc_controller
    import mc_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       lord,
    output logic       memwrite,
    output logic       regdst,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       illegal
);

    state_t r_state;
    state_t w_dec_next;
    logic   w_op_ok;
    logic   w_funct_ok;
    ctl_t   w_ctl;

    mc_aludec u_aludec (
        .i_aluop      (w_ctl.aluop),
        .i_funct      (funct),
        .o_alucontrol (alucontrol),
        .o_funct_ok   (w_funct_ok)
    );

    always_comb begin
        w_dec_next = S_FETCH;
        w_op_ok    = 1'b1;
        case (op)
            OP_LW, OP_SW: w_dec_next = S_MEMADR;
            OP_RTYPE: begin
                if (w_funct_ok) w_dec_next = S_EXECUTE;
                else            w_op_ok    = 1'b0;
            end
            OP_BEQ:  w_dec_next = S_BRANCH;
            OP_J:    w_dec_next = S_JUMP;
`ifdef MC_ADDI_EN
            OP_ADDI: w_dec_next = S_ADDIEXEC;
`endif
            default: w_op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    r_state <= S_DECODE;
                S_DECODE:   r_state <= w_dec_next;
                S_MEMADR:   r_state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:    r_state <= S_MEMWB;
                S_EXECUTE:  r_state <= S_ALUWB;
`ifdef MC_ADDI_EN
                S_ADDIEXEC: r_state <= S_ADDIWB;
`endif
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Moore control word; reset overrides it with FETCH values minus every write enable.
    always_comb begin
        w_ctl = '0;
        case (r_state)
            S_FETCH: w_ctl = fetch_ctl();
            S_DECODE: begin
                w_ctl.alusrcb = 2'b11;
                w_ctl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                w_ctl.alusrca = 1'b1;
                w_ctl.alusrcb = 2'b10;
                w_ctl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: w_ctl.lord = 1'b1;
            S_MEMWB: begin
                w_ctl.memtoreg = 1'b1;
                w_ctl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_ctl.lord     = 1'b1;
                w_ctl.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                w_ctl.alusrca = 1'b1;
                w_ctl.alusrcb = 2'b00;
                w_ctl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_ctl.regdst   = 1'b1;
                w_ctl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                w_ctl.alusrca = 1'b1;
                w_ctl.alusrcb = 2'b00;
                w_ctl.aluop   = ALUOP_SUB;
                w_ctl.pcsrc   = 2'b01;
                w_ctl.branch  = 1'b1;
            end
            S_JUMP: begin
                w_ctl.pcsrc   = 2'b10;
                w_ctl.pcwrite = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEXEC: begin
                w_ctl.alusrca = 1'b1;
                w_ctl.alusrcb = 2'b10;
                w_ctl.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: w_ctl.regwrite = 1'b1;
`endif
            default: w_ctl = '0;
        endcase

        if (reset) begin
            w_ctl         = fetch_ctl();
            w_ctl.pcwrite = 1'b0;
            w_ctl.irwrite = 1'b0;
        end
    end

    assign pcen     = w_ctl.pcwrite | (w_ctl.branch & zero);
    assign pcsrc    = w_ctl.pcsrc;
    assign alusrca  = w_ctl.alusrca;
    assign alusrcb  = w_ctl.alusrcb;
    assign irwrite  = w_ctl.irwrite;
    assign lord     = w_ctl.lord;
    assign memwrite = w_ctl.memwrite;
    assign regdst   = w_ctl.regdst;
    assign regwrite = w_ctl.regwrite;
    assign memtoreg = w_ctl.memtoreg;
    assign illegal  = ~reset & (r_state == S_DECODE) & ~w_op_ok;

endmodule
